// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//
// Central stall/flush sequencer for the 5-stage pipelined ARM core. It merges
// three sources of pipeline control into one consistent set of strobes:
//   * RAW hazard detection between the ID-stage operands and the EXE/MEM
//     destinations (no forwarding path exists, so any match must bubble),
//   * branch flush when EXE resolves a taken branch,
//   * a fixed-latency data-memory wait sequencer that holds the whole pipe
//     while a load/store occupies the MEM stage.
// Two saturating event counters (freeze cycles, flush cycles) support
// performance debug.
//
// Parameters
//   MEM_WAIT   cycles the pipeline is held per memory access (1..15)
//   CNT_W      width of the performance counters
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-high reset
//   id_valid     in   ID-stage instruction reads register operands
//   id_src1      in   ID first source register
//   id_src2      in   ID second source register
//   id_two_src   in   id_src2 is a real operand
//   exe_dest     in   EXE destination register
//   exe_wb_en    in   EXE will write back
//   mem_dest     in   MEM destination register
//   mem_wb_en    in   MEM will write back
//   mem_req      in   MEM-stage instruction is a load or store
//   branch_taken in   EXE resolved a taken branch this cycle
//   cnt_clr      in   synchronous clear of both counters
//   stall_all    out  hold every pipeline register and the PC
//   hazard       out  bubble into ID/EXE
//   freeze       out  hold the PC and the IF/ID register
//   flush        out  clear IF/ID and ID/EXE on the next edge
//   mem_busy     out  memory sequencer is not idle
//   stall_cnt    out  saturating count of cycles with freeze high
//   flush_cnt    out  saturating count of cycles with flush high
// ---------------------------------------------------------------------------
module pipeline_controller #(
  parameter int unsigned MEM_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             stall_all,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Value loaded into the wait counter on the first cycle of an access. The
  // IDLE cycle itself is the first stall cycle, hence the minus one.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wcnt;
  logic [3:0] wcnt_nxt;

  logic       raw;
  logic       stall_int;
  logic       flush_int;
  logic       hazard_int;

  // -------------------------------------------------------------------------
  // RAW detection. Full 4-bit compares; r0 is an ordinary register here.
  // The second operand only counts when the instruction really reads it.
  // -------------------------------------------------------------------------
  logic src1_exe_hit;
  logic src1_mem_hit;
  logic src2_exe_hit;
  logic src2_mem_hit;

  assign src1_exe_hit = exe_wb_en & (id_src1 == exe_dest);
  assign src1_mem_hit = mem_wb_en & (id_src1 == mem_dest);
  assign src2_exe_hit = id_two_src & exe_wb_en & (id_src2 == exe_dest);
  assign src2_mem_hit = id_two_src & mem_wb_en & (id_src2 == mem_dest);

  assign raw = id_valid & (src1_exe_hit | src1_mem_hit | src2_exe_hit | src2_mem_hit);

  // -------------------------------------------------------------------------
  // Memory wait sequencer: state register.
  // A reset in the middle of an access abandons it outright.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Memory wait sequencer: next-state logic.
  // DONE is the single cycle in which the access instruction is released
  // from MEM; mem_req is deliberately not looked at there, so a following
  // access is picked up from IDLE one cycle later.
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so that no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      S_IDLE: begin
        if (mem_req) begin
          wcnt_nxt  = WAIT_LOAD;
          state_nxt = (MEM_WAIT == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt == 4'd1) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. Priority: memory stall > branch flush > RAW bubble.
  // A branch seen while stalled is dropped on purpose: the EXE instruction is
  // held, so it presents the branch again once the stall releases. Likewise a
  // branch kills the ID instruction, so a RAW bubble behind it is pointless.
  // All strobes are forced low while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_int  = 1'b0;
    unique case (state)
      S_IDLE:  stall_int = mem_req;
      S_WAIT:  stall_int = 1'b1;
      default: stall_int = 1'b0;
    endcase

    flush_int  = branch_taken & ~stall_int;
    hazard_int = raw & ~branch_taken & ~stall_int;

    stall_all  = ~rst & stall_int;
    flush      = ~rst & flush_int;
    hazard     = ~rst & hazard_int;
    freeze     = ~rst & (stall_int | hazard_int);
    mem_busy   = ~rst & (state != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Performance counters. Clear wins over increment; both saturate at
  // all-ones so a long run never wraps back to a misleadingly small value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (freeze && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      flush_cnt <= '0;
    end else if (flush && !(&flush_cnt)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller
//
// Directed bench for pipeline_controller. Three instances share one set of
// inputs: dut4 (MEM_WAIT=4, CNT_W=16), dut1 (MEM_WAIT=1) for back-to-back
// accesses, and dutc (CNT_W=4) for counter saturation. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_controller;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        mem_req;
  logic        branch_taken;
  logic        cnt_clr;

  logic        stall4, hazard4, freeze4, flush4, busy4;
  logic [15:0] scnt4, fcnt4;
  logic        stall1, hazard1, freeze1, flush1, busy1;
  logic [15:0] scnt1, fcnt1;
  logic        stallc, hazardc, freezec, flushc, busyc;
  logic [3:0]  scntc, fcntc;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle behaviour for a held mem_req, starting in IDLE.
  int exp_stall4 [6] = '{1, 1, 1, 1, 0, 1};
  int exp_busy4  [6] = '{0, 1, 1, 1, 1, 0};
  int exp_scnt4  [6] = '{0, 1, 2, 3, 4, 4};
  int exp_stall1 [6] = '{1, 0, 1, 0, 1, 0};
  int exp_busy1  [6] = '{0, 1, 0, 1, 0, 1};

  pipeline_controller #(.MEM_WAIT(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .stall_all(stall4), .hazard(hazard4), .freeze(freeze4), .flush(flush4),
    .mem_busy(busy4), .stall_cnt(scnt4), .flush_cnt(fcnt4)
  );

  pipeline_controller #(.MEM_WAIT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .stall_all(stall1), .hazard(hazard1), .freeze(freeze1), .flush(flush1),
    .mem_busy(busy1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  pipeline_controller #(.MEM_WAIT(4), .CNT_W(4)) dutc (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .stall_all(stallc), .hazard(hazardc), .freeze(freezec), .flush(flushc),
    .mem_busy(busyc), .stall_cnt(scntc), .flush_cnt(fcntc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset with every stall/flush source active.
    rst = 1'b1; id_valid = 1'b1; id_src1 = 4'd3; id_src2 = 4'd0;
    id_two_src = 1'b0; exe_dest = 4'd3; exe_wb_en = 1'b1; mem_dest = 4'd0;
    mem_wb_en = 1'b0; mem_req = 1'b1; branch_taken = 1'b1; cnt_clr = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    check("rst_stall_all", 16'(stall4), 16'd0);
    check("rst_hazard",    16'(hazard4), 16'd0);
    check("rst_freeze",    16'(freeze4), 16'd0);
    check("rst_flush",     16'(flush4), 16'd0);
    check("rst_mem_busy",  16'(busy4), 16'd0);
    check("rst_stall_cnt", scnt4, 16'd0);
    check("rst_flush_cnt", fcnt4, 16'd0);

    // Release with mem_req high: stall in the very same cycle.
    next_cycle();
    rst = 1'b0; branch_taken = 1'b0; id_valid = 1'b0;
    sample();
    check("rel_stall4", 16'(stall4), 16'd1);
    check("rel_stall1", 16'(stall1), 16'd1);
    check("rel_busy4",  16'(busy4), 16'd0);
    next_cycle();
    mem_req = 1'b0;
    sample();
    check("wait_busy4", 16'(busy4), 16'd1);

    // Reset in the middle of an access aborts it.
    next_cycle();
    rst = 1'b1;
    sample();
    check("midrst_busy",  16'(busy4), 16'd0);
    check("midrst_stall", 16'(stall4), 16'd0);
    next_cycle();
    rst = 1'b0;
    sample();
    check("postrst_busy",  16'(busy4), 16'd0);
    check("postrst_stall", 16'(stall4), 16'd0);

    // Memory wait with mem_req held; dut1 shows back-to-back accesses.
    next_cycle();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    mem_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      sample();
      check($sformatf("mw4_stall_c%0d", k), 16'(stall4), 16'(exp_stall4[k]));
      check($sformatf("mw4_busy_c%0d", k),  16'(busy4),  16'(exp_busy4[k]));
      check($sformatf("mw4_scnt_c%0d", k),  scnt4,       16'(exp_scnt4[k]));
      check($sformatf("mw1_stall_c%0d", k), 16'(stall1), 16'(exp_stall1[k]));
      check($sformatf("mw1_busy_c%0d", k),  16'(busy1),  16'(exp_busy1[k]));
    end
    next_cycle();
    mem_req = 1'b0;
    repeat (6) next_cycle();
    sample();
    check("mw_idle4", 16'(busy4), 16'd0);
    check("mw_idle1", 16'(busy1), 16'd0);

    // RAW detection.
    next_cycle();
    id_valid = 1'b1; id_src1 = 4'd1; id_src2 = 4'd3; id_two_src = 1'b0;
    exe_dest = 4'd3; exe_wb_en = 1'b1; mem_dest = 4'd0; mem_wb_en = 1'b0;
    sample();
    check("raw_src2_unused_hz", 16'(hazard4), 16'd0);
    check("raw_src2_unused_fz", 16'(freeze4), 16'd0);
    next_cycle();
    id_two_src = 1'b1;
    sample();
    check("raw_src2_exe_hz", 16'(hazard4), 16'd1);
    check("raw_src2_exe_fz", 16'(freeze4), 16'd1);
    check("raw_src2_exe_st", 16'(stall4), 16'd0);
    check("raw_src2_exe_fl", 16'(flush4), 16'd0);
    next_cycle();
    id_two_src = 1'b0; mem_dest = 4'd5; mem_wb_en = 1'b1; id_src1 = 4'd5;
    sample();
    check("raw_src1_mem_hz", 16'(hazard4), 16'd1);
    next_cycle();
    id_src1 = 4'd13;
    sample();
    check("raw_msb_diff_hz", 16'(hazard4), 16'd0);
    next_cycle();
    id_src1 = 4'd0; mem_dest = 4'd0;
    sample();
    check("raw_r0_hz", 16'(hazard4), 16'd1);
    next_cycle();
    id_valid = 1'b0;
    sample();
    check("raw_invalid_hz", 16'(hazard4), 16'd0);

    // Branch priority over RAW, and masking during a memory stall.
    next_cycle();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0; id_valid = 1'b1; id_src1 = 4'd5; mem_dest = 4'd5;
    mem_wb_en = 1'b1; exe_wb_en = 1'b0; branch_taken = 1'b1;
    sample();
    check("br_flush",  16'(flush4), 16'd1);
    check("br_hazard", 16'(hazard4), 16'd0);
    check("br_freeze", 16'(freeze4), 16'd0);
    check("br_fcnt0",  fcnt4, 16'd0);
    next_cycle();
    branch_taken = 1'b0;
    sample();
    check("br_fcnt1",      fcnt4, 16'd1);
    check("br_raw_return", 16'(hazard4), 16'd1);
    next_cycle();
    mem_req = 1'b1;
    sample();
    check("br_idle_req_stall", 16'(stall4), 16'd1);
    check("br_idle_req_hz",    16'(hazard4), 16'd0);
    next_cycle();
    mem_req = 1'b0; branch_taken = 1'b1;
    sample();
    check("br_wait_flush",  16'(flush4), 16'd0);
    check("br_wait_hazard", 16'(hazard4), 16'd0);
    check("br_wait_freeze", 16'(freeze4), 16'd1);
    next_cycle();
    sample();
    check("br_wait_fcnt", fcnt4, 16'd1);
    branch_taken = 1'b0;
    repeat (5) next_cycle();

    // Counter saturation and clear on the 4-bit instance.
    cnt_clr = 1'b1; id_valid = 1'b0;
    next_cycle();
    cnt_clr = 1'b0; id_valid = 1'b1; id_src1 = 4'd5; mem_dest = 4'd5;
    mem_wb_en = 1'b1; exe_wb_en = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (k == 0)  check("sat_hazard_on", 16'(hazardc), 16'd1);
      if (k == 14) check("sat_c14", 16'(scntc), 16'd14);
      if (k == 15) check("sat_c15", 16'(scntc), 16'd15);
      if (k == 19) check("sat_c19", 16'(scntc), 16'd15);
      next_cycle();
    end
    cnt_clr = 1'b1;
    sample();
    check("clr_before", 16'(scntc), 16'd15);
    next_cycle();
    cnt_clr = 1'b0;
    sample();
    check("clr_after", 16'(scntc), 16'd0);
    next_cycle();
    sample();
    check("clr_restart", 16'(scntc), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the 5-stage pipelined ARM core. It combines load/RAW hazard detection, branch flush, and a fixed-latency data-memory wait state machine into one set of pipeline-control strobes. These strobes drive the IF stage `freeze`, the ID stage `hazard` bubble, the IF/ID and ID/EXE flush, and a global hold of all pipeline registers. Saturating stall and flush event counters support performance debug.

## Interface
Parameters:
- `MEM_WAIT`, default 4: cycles the MEM stage holds the pipeline per memory access; legal range 1..15.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `id_valid`  in  1  ID-stage instruction reads register operands.
- `id_src1`  in  4  ID first source register.
- `id_src2`  in  4  ID second source register.
- `id_two_src`  in  1  `id_src2` is a real operand (register-form or store).
- `exe_dest`  in  4  EXE destination register.
- `exe_wb_en`  in  1  EXE will write back.
- `mem_dest`  in  4  MEM destination register.
- `mem_wb_en`  in  1  MEM will write back.
- `mem_req`  in  1  MEM-stage instruction is a load or store.
- `branch_taken`  in  1  EXE resolved a taken branch this cycle.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `stall_all`  out  1  hold every pipeline register and the PC.
- `hazard`  out  1  insert a bubble into ID/EXE (zero its control bits).
- `freeze`  out  1  hold the PC and the IF/ID register.
- `flush`  out  1  clear IF/ID and ID/EXE on the next edge.
- `mem_busy`  out  1  FSM is not IDLE.
- `stall_cnt`  out  CNT_W  cycles with `freeze` high.
- `flush_cnt`  out  CNT_W  cycles with `flush` high.

## Operation
- RAW condition: `raw = id_valid & ( (exe_wb_en & id_src1==exe_dest) | (mem_wb_en & id_src1==mem_dest) | (id_two_src & exe_wb_en & id_src2==exe_dest) | (id_two_src & mem_wb_en & id_src2==mem_dest) )`.
  - There is no forwarding.
  - All 4 register bits are compared; r0 is a normal register.
- Memory FSM states: IDLE, WAIT, DONE. A 4-bit down-counter `wcnt` supports it.
  - IDLE, `mem_req`=1: `stall_all`=1; `wcnt`<=MEM_WAIT-1; next state is DONE if MEM_WAIT==1, else WAIT.
  - IDLE, `mem_req`=0: remain in IDLE.
  - WAIT: `stall_all`=1; `wcnt`<=`wcnt`-1; go to DONE when `wcnt`==1.
  - DONE: `stall_all`=0, so the access instruction leaves MEM at this edge; go to IDLE unconditionally.
  - In DONE, `mem_req` is ignored. A back-to-back memory op is seen in IDLE on the next cycle.
- Output priority (combinational from state and inputs):
  - `stall_all` = (IDLE & `mem_req`) | WAIT.
  - `flush` = `branch_taken` & ~`stall_all`.
  - `hazard` = `raw` & ~`branch_taken` & ~`stall_all`.
  - `freeze` = `stall_all` | `hazard`.
  - `mem_busy` = state != IDLE.
- Counters:
  - Each counter increments by 1 per cycle its event is high and saturates at all-ones.
  - `cnt_clr` has priority over increment; the counter reads 0 on the next cycle.

## Timing
- During reset: state IDLE, `wcnt`=0, both counters 0, and all single-bit outputs forced to 0 regardless of inputs.
- Reset asserted mid-access aborts the access immediately. After release, the FSM is in IDLE and re-evaluates `mem_req`.
- `hazard`, `flush`, and `freeze` have zero latency: they are valid in the same cycle as their inputs and take effect at the next edge.
- A memory access first seen at cycle t:
  - `stall_all` is high for cycles t..t+MEM_WAIT-1.
  - `stall_all` is low at t+MEM_WAIT (DONE).
  - Total MEM occupancy is MEM_WAIT+1 cycles.
- `branch_taken` together with `raw`: `flush`=1 and `hazard`=0.
- `branch_taken` during `stall_all`: both masked. The EXE instruction is held, so `branch_taken` re-presents after the stall releases.
- A `raw` condition persists until the producer retires. `hazard` stays high for every such cycle; no internal state is needed.

## Test plan
- Reset: `rst`=1 with `mem_req`=1 and `branch_taken`=1. Required: all outputs 0 and counters 0. After release with `mem_req`=1: `stall_all`=1 in the same cycle.
- Memory wait, MEM_WAIT=4: pulse `mem_req` at cycle 10 and hold it. Required: `stall_all` high for cycles 10–13 and low at 14; `mem_busy` high for 11–14; `stall_cnt`=4.
- Back-to-back access, MEM_WAIT=1: `mem_req` high for 4 cycles. Required: `stall_all` pattern 1,0,1,0; states IDLE→DONE→IDLE→DONE.
- RAW: `id_valid`=1, `id_src2`=3, `id_two_src`=0, `exe_dest`=3, `exe_wb_en`=1. Required: `hazard`=0. Then set `id_two_src`=1: `hazard`=1 and `freeze`=1. Then `mem_dest`=5 with `mem_wb_en`=1 and `id_src1`=5: `hazard`=1.
- Branch priority: `raw` true and `branch_taken`=1. Required: `flush`=1, `hazard`=0, `freeze`=0, `flush_cnt`=1. The same inputs during the WAIT state give `flush`=0.
- Counter saturation and clear, CNT_W=4: hold `hazard` for 20 cycles. Required: `stall_cnt`=15 and held there. Then `cnt_clr`=1 with `hazard`=1: `stall_cnt`=0 on the next cycle.
